fetch_flush_ctrl: RTL
=====================

Name: fetch_flush_ctrl

Overview:
- Sequences instruction-memory fetch requests for the front end, tracking in-flight requests against a credit count from the instruction queue.
- On a committed branch mispredict, it redirects the fetch PC immediately and discards stale imem responses still in flight.
- It does not wait for the memory to go idle.
- Sits between the ROB commit port, the imem port and the instruction queue; produces the global flush pulse.

Parameters:
- MAX_OUT, 4, maximum outstanding imem requests (power of 2, >=2).
- RESET_PC, 32'h1eceb000, fetch PC after reset.
- IQ_CW, 4, width of the iq_free credit input.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (block resets while rst==0).
- rob_valid  in  1  ROB head valid.
- rob_ready  in  1  ROB head committing this cycle.
- flush_branch  in  1  committing head is a mispredicted branch.
- flush_pc  in  32  correct target for the redirect.
- imem_rqst  out  1  one-cycle request pulse; the memory accepts every pulse, and responses return in order.
- imem_addr  out  32  request address, valid with imem_rqst.
- imem_resp  in  1  response valid; at most one per cycle.
- imem_rdata  in  32  instruction data.
- iq_free  in  IQ_CW  free instruction-queue entries this cycle.
- iq_valid  out  1  forward instruction to IQ.
- iq_inst  out  32  instruction.
- iq_pc  out  32  PC of the forwarded instruction.
- move_flush  out  1  single-cycle global flush pulse.

Behaviour:
- flush_take = rob_valid & rob_ready & flush_branch (combinational); move_flush = flush_take in every state except IDLE.
- Reset values:
  - state=IDLE, pc=RESET_PC, out_cnt=0, drop_cnt=0.
  - PC FIFO empty.
  - imem_rqst=0, iq_valid=0, move_flush=0.
- States:
  - IDLE: entered only by reset; always goes to RUN the next cycle. No requests are issued. flush_take is ignored.
  - RUN: drop_cnt==0; responses are forwarded.
  - DRAIN: drop_cnt!=0; responses are consumed silently, and drop_cnt decrements on each one. Go to RUN when drop_cnt is 1 and imem_resp=1, unless flush_take.
- Counters:
  - out_cnt counts issued-but-unanswered requests, width $clog2(MAX_OUT+1).
  - live = out_cnt - drop_cnt.
  - out_cnt_next = out_cnt + imem_rqst - imem_resp. It never exceeds MAX_OUT and never underflows; an imem_resp with out_cnt==0 is a protocol error (assertion).
- Issue:
  - imem_rqst = state!=IDLE & !flush_take & out_cnt<MAX_OUT & live<iq_free.
  - imem_addr = pc. On issue: pc <= pc+4, and pc is pushed into the PC FIFO.
  - Requests may issue while in DRAIN; new requests are younger than the stale ones, so no extra state is needed.
- Response:
  - Every imem_resp pops the PC FIFO.
  - iq_valid = imem_resp & drop_cnt==0 & !flush_take; iq_inst = imem_rdata; iq_pc = FIFO head.
- Flush (flush_take in RUN or DRAIN):
  - pc <= flush_pc.
  - No issue that cycle; the next cycle may issue flush_pc.
  - drop_cnt <= out_cnt - imem_resp, because a response arriving in the same cycle is itself dropped (not forwarded) and already popped.
  - state <= DRAIN if that value is nonzero, else RUN.
  - Back-to-back flushes: each one recomputes drop_cnt from the current out_cnt.
- Reset mid-operation: all state clears immediately (async), and outputs return to reset values. The imem must also be reset; responses after reset with out_cnt==0 are errors.
- No combinational path from imem_rdata to imem_rqst. imem_rqst depends combinationally on the flush inputs and iq_free.

Decomposition:
- Shared package fetch_pkg holds:
  - enum fetch_state_t {IDLE, RUN, DRAIN} (2-bit);
  - localparam RESET_PC;
  - typedef pc_t (logic [31:0]).
- One sub-module, pc_fifo: MAX_OUT-deep in-order FIFO of pc_t with push/pop/head/full/empty, wrap-around pointers with an extra bit, and async active-low reset.
- Push and pop in the same cycle are legal when the FIFO is non-empty.

Test Plan:
- Reset release, imem returning each response 1 cycle after request, iq_free=8 -> issues at 0x1eceb000, +4, +8, ...; iq_pc matches; out_cnt never exceeds MAX_OUT=4.
- imem latency 10, iq_free=8 -> exactly 4 requests outstanding; issue resumes the cycle after the first response.
- Three requests outstanding, flush_take with flush_pc=0x1000 -> move_flush pulses 1 cycle; drop_cnt=3; the next 3 responses produce iq_valid=0; the response to 0x1000 is forwarded with iq_pc=0x1000.
- flush_take coincident with imem_resp and out_cnt=2 -> that response is dropped, drop_cnt=1, no imem_rqst that cycle.
- iq_free=0 for 20 cycles with out_cnt=0 -> imem_rqst stays 0; when iq_free becomes 2 -> exactly 2 requests issue.
- rst asserted while in DRAIN with drop_cnt=2 -> all outputs 0 immediately; after release, state IDLE then RUN and first address=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/flush front-end slice.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC = 32'h1eceb000;

    typedef logic [31:0] pc_t;

endpackage

// File: rtl/pc_fifo.sv
// In-order FIFO holding the PC of every outstanding imem request.
// Its head is the PC that belongs to the next response.
module pc_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [31:0] push_pc,
    input  logic        pop,
    output logic [31:0] head,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    pc_t          mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    // The extra pointer bit tells full from empty when the index bits match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_pc;
        end
    end

endmodule

// File: rtl/fetch_flush_ctrl.sv
// Fetch request sequencer: issues imem requests against IQ credit and, on a
// committed mispredict, redirects the PC and silently drops stale responses.
module fetch_flush_ctrl
    import fetch_pkg::*;
#(
    parameter int          MAX_OUT  = 4,
    parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter int          IQ_CW    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rob_valid,
    input  logic                           rob_ready,
    input  logic                           flush_branch,
    input  logic [31:0]                    flush_pc,
    output logic                           imem_rqst,
    output logic [31:0]                    imem_addr,
    input  logic                           imem_resp,
    input  logic [31:0]                    imem_rdata,
    input  logic [IQ_CW-1:0]               iq_free,
    output logic                           iq_valid,
    output logic [31:0]                    iq_inst,
    output logic [31:0]                    iq_pc,
    output logic                           move_flush,
    output logic [1:0]                     dbg_state,
    output logic [$clog2(MAX_OUT+1)-1:0]   dbg_out_cnt,
    output logic [$clog2(MAX_OUT+1)-1:0]   dbg_drop_cnt
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int MW = (CW > IQ_CW) ? CW : IQ_CW;

    fetch_state_t   state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [CW-1:0]  out_cnt_q, out_cnt_d;
    logic [CW-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]  live, flush_drop;
    logic           flush_take, flush_en, issue;
    logic [31:0]    fifo_head;
    logic           fifo_full, fifo_empty;

    // Handshake: imem_rqst is a one-cycle pulse the memory always accepts;
    // imem_resp returns at most one in-order response per cycle; iq_valid
    // is a pulse that the IQ accepts because issue is bounded by iq_free.
    assign flush_take = rob_valid & rob_ready & flush_branch;
    assign flush_en   = flush_take && (state_q != IDLE);
    assign live       = out_cnt_q - drop_cnt_q;
    // A response landing in the flush cycle is dropped and already popped.
    assign flush_drop = out_cnt_q - CW'(imem_resp);
    assign issue      = (state_q != IDLE) && !flush_take && !fifo_full &&
                        (out_cnt_q < CW'(MAX_OUT)) && (MW'(live) < MW'(iq_free));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        out_cnt_d  = out_cnt_q + CW'(issue) - CW'(imem_resp);
        case (state_q)
            IDLE: state_d = RUN;
            RUN, DRAIN: begin
                if (flush_en) begin
                    pc_d       = flush_pc;
                    drop_cnt_d = flush_drop;
                    state_d    = (flush_drop != '0) ? DRAIN : RUN;
                end else begin
                    if (issue) begin
                        pc_d = pc_q + 32'd4;
                    end
                    if (state_q == DRAIN && imem_resp) begin
                        drop_cnt_d = drop_cnt_q - CW'(1);
                        if (drop_cnt_q == CW'(1)) begin
                            state_d = RUN;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_rqst    = issue;
        imem_addr    = pc_q;
        move_flush   = flush_en;
        iq_valid     = imem_resp && !fifo_empty && (drop_cnt_q == '0) && !flush_take;
        iq_inst      = imem_rdata;
        iq_pc        = fifo_head;
        dbg_state    = state_q;
        dbg_out_cnt  = out_cnt_q;
        dbg_drop_cnt = drop_cnt_q;
    end

    pc_fifo #(
        .DEPTH (MAX_OUT)
    ) u_pc_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push    (issue),
        .push_pc (pc_q),
        .pop     (imem_resp),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    resp_needs_outstanding: assert property (
        @(posedge clk) disable iff (!rst) !(imem_resp && out_cnt_q == '0)
    );

endmodule
